// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the sequential magnitude comparator.
package cmp_pkg;

    localparam int CMP_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_result_t;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for the sequential magnitude comparator.
interface seq_magnitude_comparator_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_signed;
    logic             o_valid;
    logic             i_ready;
    logic             o_eq;
    logic             o_lt;
    logic             o_gt;

    // Producer/consumer side driving operands and taking results.
    modport master (
        output i_valid, i_a, i_b, i_signed, i_ready,
        input  o_ready, o_valid, o_eq, o_lt, o_gt
    );

    // Comparator side.
    modport slave (
        input  i_valid, i_a, i_b, i_signed, i_ready,
        output o_ready, o_valid, o_eq, o_lt, o_gt
    );
endinterface

// File: rtl/seq_magnitude_comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle
// from the MSB and stops at the first differing chunk. Signed operands are
// stored in offset-binary (MSB flipped) so the chunk compare stays unsigned.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH,
    parameter int CHUNK = 4
) (
    input logic                       i_clk,
    input logic                       i_rst,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    cmp_state_e       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_result_t      res_q, res_d;

    logic [WIDTH-1:0] sign_mask;
    logic [NCHUNK-1:0][CHUNK-1:0] a_ch;
    logic [NCHUNK-1:0][CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic             c_lt;
    logic             c_gt;

    // Only the operand MSB is flipped for the signed-to-offset-binary mapping.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = 1'b1;
    end

    assign a_ch = a_q;
    assign b_ch = b_q;

    generate
        if (NCHUNK == 1) begin : g_one
            assign a_sel = a_ch[0];
            assign b_sel = b_ch[0];
        end else begin : g_many
            assign a_sel = a_ch[idx_q];
            assign b_sel = b_ch[idx_q];
        end
    endgenerate

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_sel),
        .b  (b_sel),
        .lt (c_lt),
        .gt (c_gt)
    );

    // Next-state, operand capture, chunk walk and result update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a ^ (bus.i_signed ? sign_mask : '0);
                    b_d     = bus.i_b ^ (bus.i_signed ? sign_mask : '0);
                    idx_d   = IDX_TOP;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (c_gt) begin
                    res_d.gt = 1'b1;
                    state_d  = DONE;
                end else if (c_lt) begin
                    res_d.lt = 1'b1;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    res_d.eq = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                // Result is held until the consumer takes it.
                if (bus.i_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, operand and result registers; reset drops everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_eq    = res_q.eq;
    assign bus.o_lt    = res_q.lt;
    assign bus.o_gt    = res_q.gt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator across four width/chunk configs.
module tb_seq_magnitude_comparator;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(32)) if0 ();
    seq_magnitude_comparator_if #(.WIDTH(16)) if1 ();
    seq_magnitude_comparator_if #(.WIDTH(32)) if2 ();
    seq_magnitude_comparator_if #(.WIDTH(64)) if3 ();

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(4))  u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1))  u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(32)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));
    seq_magnitude_comparator #(.WIDTH(64), .CHUNK(8))  u3 (.i_clk(clk), .i_rst(rst), .bus(if3));

    function automatic int wid(input int d);
        case (d)
            0: return 32;
            1: return 16;
            2: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int csz(input int d);
        case (d)
            0: return 4;
            1: return 1;
            2: return 32;
            default: return 8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic sg);
        case (d)
            0: begin if0.i_valid = v; if0.i_a = a[31:0]; if0.i_b = b[31:0]; if0.i_signed = sg; end
            1: begin if1.i_valid = v; if1.i_a = a[15:0]; if1.i_b = b[15:0]; if1.i_signed = sg; end
            2: begin if2.i_valid = v; if2.i_a = a[31:0]; if2.i_b = b[31:0]; if2.i_signed = sg; end
            default: begin if3.i_valid = v; if3.i_a = a; if3.i_b = b; if3.i_signed = sg; end
        endcase
    endtask

    task automatic set_rdy(input int d, input logic r);
        case (d)
            0: if0.i_ready = r;
            1: if1.i_ready = r;
            2: if2.i_ready = r;
            default: if3.i_ready = r;
        endcase
    endtask

    task automatic sample(input int d, output logic v, output logic r, output logic [2:0] f);
        case (d)
            0: begin v = if0.o_valid; r = if0.o_ready; f = {if0.o_eq, if0.o_lt, if0.o_gt}; end
            1: begin v = if1.o_valid; r = if1.o_ready; f = {if1.o_eq, if1.o_lt, if1.o_gt}; end
            2: begin v = if2.o_valid; r = if2.o_ready; f = {if2.o_eq, if2.o_lt, if2.o_gt}; end
            default: begin v = if3.o_valid; r = if3.o_ready; f = {if3.o_eq, if3.o_lt, if3.o_gt}; end
        endcase
    endtask

    task automatic scramble(input int d);
        drive(d, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    endtask

    // Reference: whole-word compare plus latency from the highest differing bit.
    task automatic model(input int d, input logic [63:0] a, input logic [63:0] b,
                         input logic sg, output int lat, output logic [2:0] f);
        int w;
        int c;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] diff;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        w    = wid(d);
        c    = csz(d);
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        if (sg) begin
            sa = am << (64 - w);
            sb = bm << (64 - w);
            f  = (sa == sb) ? EQ : ((sa < sb) ? LT : GT);
        end else begin
            f  = (am == bm) ? EQ : ((am < bm) ? LT : GT);
        end
        diff = am ^ bm;
        lat  = w / c;
        for (int i = w - 1; i >= 0; i--) begin
            if (diff[i]) begin
                lat = w / c - i / c;
                break;
            end
        end
    endtask

    task automatic run_cmp(input int d, input logic [63:0] a, input logic [63:0] b,
                           input logic sg, input int exp_lat, input logic [2:0] exp_f,
                           input int hold, input string tag);
        logic v;
        logic r;
        logic [2:0] f;
        int lat;
        @(negedge clk);
        drive(d, 1'b1, a, b, sg);
        sample(d, v, r, f);
        check({tag, " ready_idle"}, 64'(r), 64'd1);
        @(posedge clk);
        #1;
        scramble(d);
        lat = 0;
        v   = 1'b0;
        while (!v && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            sample(d, v, r, f);
            check({tag, " ready_busy"}, 64'(r), 64'd0);
            scramble(d);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " flags"}, 64'(f), 64'(exp_f));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            sample(d, v, r, f);
            check({tag, " hold_valid"}, 64'(v), 64'd1);
            check({tag, " hold_flags"}, 64'(f), 64'(exp_f));
            scramble(d);
        end
        @(negedge clk);
        set_rdy(d, 1'b1);
        @(posedge clk);
        #1;
        set_rdy(d, 1'b0);
        sample(d, v, r, f);
        check({tag, " handoff_valid"}, 64'(v), 64'd0);
        check({tag, " handoff_ready"}, 64'(r), 64'd1);
        check({tag, " handoff_flags"}, 64'(f), 64'd0);
    endtask

    task automatic run_model(input int d, input logic [63:0] a, input logic [63:0] b,
                             input logic sg, input string tag);
        int lat;
        logic [2:0] f;
        model(d, a, b, sg, lat, f);
        run_cmp(d, a, b, sg, lat, f, 0, tag);
    endtask

    initial begin
        logic v;
        logic r;
        logic [2:0] f;
        logic [63:0] ra;
        logic [63:0] rb;
        for (int d = 0; d < 4; d++) begin
            drive(d, 1'b0, '0, '0, 1'b0);
            set_rdy(d, 1'b0);
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            sample(d, v, r, f);
            check($sformatf("reset%0d valid", d), 64'(v), 64'd0);
            check($sformatf("reset%0d ready", d), 64'(r), 64'd1);
            check($sformatf("reset%0d flags", d), 64'(f), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // i_ready while idle must not disturb anything
        set_rdy(0, 1'b1);
        @(posedge clk);
        #1;
        set_rdy(0, 1'b0);
        sample(0, v, r, f);
        check("idle_rdy valid", 64'(v), 64'd0);
        check("idle_rdy ready", 64'(r), 64'd1);

        run_cmp(0, 64'h1234_5678, 64'h1234_5678, 1'b0, 8, EQ, 0, "eq32");
        run_cmp(0, 64'h9000_0000, 64'h1000_0000, 1'b0, 1, GT, 0, "msb_exit");
        run_cmp(0, 64'hFFFF_FFFF, 64'h0000_0001, 1'b1, 1, LT, 0, "neg1_signed");
        run_cmp(0, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1, GT, 0, "neg1_unsigned");
        run_cmp(0, 64'h0000_0003, 64'h0000_0005, 1'b1, 8, LT, 0, "lsb_chunk");
        run_cmp(0, 64'h0000_0100, 64'h0000_0200, 1'b0, 6, LT, 5, "backpressure");

        // async reset during the third compare cycle
        @(negedge clk);
        drive(0, 1'b1, 64'h1234_5678, 64'h1234_5678, 1'b0);
        @(posedge clk);
        #1;
        scramble(0);
        @(posedge clk);
        @(posedge clk);
        #1;
        sample(0, v, r, f);
        check("midrst busy_ready", 64'(r), 64'd0);
        check("midrst busy_valid", 64'(v), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(0, v, r, f);
        check("midrst valid", 64'(v), 64'd0);
        check("midrst flags", 64'(f), 64'd0);
        check("midrst ready", 64'(r), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_cmp(0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, 1, LT, 0, "post_rst");

        // 16-bit, 1-bit chunks
        run_cmp(1, 64'h8000, 64'h7FFF, 1'b0, 1, GT, 0, "w16 unsigned_msb");
        run_cmp(1, 64'h8000, 64'h7FFF, 1'b1, 1, LT, 0, "w16 signed_msb");
        run_cmp(1, 64'h1234, 64'h1235, 1'b0, 16, LT, 0, "w16 lsb");
        run_cmp(1, 64'hBEEF, 64'hBEEF, 1'b1, 16, EQ, 0, "w16 eq");

        // 32-bit, single chunk
        run_cmp(2, 64'hFFFF_FFFF, 64'h0000_0001, 1'b1, 1, LT, 0, "w32c32 signed");
        run_cmp(2, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1, EQ, 2, "w32c32 eq");
        run_cmp(2, 64'h0000_0005, 64'h0000_0003, 1'b0, 1, GT, 0, "w32c32 gt");

        // 64-bit, byte chunks
        run_cmp(3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_88AB_CDEF, 1'b0, 5, GT, 0, "w64 byte3");
        run_cmp(3, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1, LT, 0, "w64 signed");
        run_cmp(3, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 1'b0, 8, EQ, 0, "w64 eq");

        // randomised operands, mostly a single flipped bit so latency varies
        for (int d = 1; d < 4; d++) begin
            for (int i = 0; i < 5; i++) begin
                ra = {$urandom, $urandom};
                rb = (i == 4) ? ra : (ra ^ (64'd1 << $urandom_range(wid(d) - 1, 0)));
                run_model(d, ra, rb, 1'($urandom), $sformatf("rand d%0d i%0d", d, i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for the branch/ALU compare path.
- Successor to the fixed 32-bit ripple comparator: generic width and chunk size, signed and unsigned modes, and valid/ready handshakes on input and output.
- Compares CHUNK bits per cycle, MSB-first, and terminates early on the first differing chunk.
- Produces registered eq/lt/gt flags held until the consumer accepts them.

Parameters:
- WIDTH, 32, operand width in bits; must satisfy WIDTH % CHUNK == 0.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operands and mode present.
- o_ready  out  1  block can accept operands; high only in IDLE.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_signed  in  1  1 = two's-complement compare; 0 = unsigned compare.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_eq  out  1  A == B.
- o_lt  out  1  A < B in the selected mode.
- o_gt  out  1  A > B in the selected mode.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; o_valid, o_eq, o_lt, o_gt = 0.
  - Chunk index = 0; operand registers = 0.
  - o_ready = 1 (it is decoded from IDLE).
  - i_valid is ignored while i_rst is high.
- States and transitions: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready at an edge: latch operands, set idx = NCHUNK-1, go to RUN.
  - Signed mode: latch the operands with the MSB inverted (offset-binary), so an unsigned chunk compare yields the signed result.
- RUN, one chunk per cycle, comparing latched a[idx*CHUNK +: CHUNK] against b[...]:
  - a-chunk > b-chunk: gt = 1, go to DONE.
  - a-chunk < b-chunk: lt = 1, go to DONE.
  - Chunks equal and idx == 0: eq = 1, go to DONE.
  - Chunks equal and idx > 0: idx decrements, stay in RUN.
- DONE:
  - o_valid = 1; flags are stable and exactly one of eq/lt/gt is 1.
  - On i_valid-independent i_ready = 1 at an edge: clear o_valid and all flags, go to IDLE.
  - o_ready = 0, so no new operand is accepted in the same cycle as the result handoff.
- Latency:
  - First differing chunk found at the k-th compare (k = 1..NCHUNK): o_valid rises k edges after the accept edge.
  - Equal operands: o_valid rises NCHUNK edges after the accept edge (8 for the defaults).
- Throughput: at most one compare per k+2 cycles.
- Input stability: i_a, i_b and i_signed may change freely after acceptance; only the latched copies are used.
- Backpressure: o_valid and the flags hold indefinitely while i_ready = 0.
- Reset mid-operation (RUN or DONE): immediate return to IDLE, the result is discarded, o_valid drops asynchronously.
- CHUNK == WIDTH: a single compare cycle, so o_valid follows one edge after accept.
- i_ready asserted outside DONE: no effect.

Decomposition:
- Package cmp_pkg:
  - cmp_state_e enum {IDLE, RUN, DONE}.
  - cmp_result_t packed struct {eq, lt, gt}.
  - Constant for the default width (32).
- Sub-module cmp_chunk: purely combinational CHUNK-bit unsigned compare producing lt/gt; instantiated once and indexed by idx.
- The parent holds the FSM, operand registers, idx counter and result register.

Test Plan:
- Unsigned, equal: A=0x1234_5678, B=0x1234_5678, i_signed=0 -> o_valid 8 edges after accept; eq=1, lt=0, gt=0.
- Early exit at MSB chunk: A=0x9000_0000, B=0x1000_0000, unsigned -> o_valid 1 edge after accept; gt=1.
- Signed vs unsigned on the same operands, A=0xFFFF_FFFF, B=0x0000_0001:
  - i_signed=1 -> lt=1 after 1 edge.
  - i_signed=0 -> gt=1 after 1 edge.
- Difference only in the LSB chunk: A=0x0000_0003, B=0x0000_0005, signed -> lt=1 after 8 edges; o_ready=0 throughout.
- Backpressure and stability: hold i_ready=0 for 5 cycles after o_valid; toggle i_a/i_b during RUN and DONE -> flags unchanged; one edge with i_ready=1 returns to IDLE with o_ready=1 and o_valid=0.
- Async reset mid-RUN: assert i_rst between edges during the 3rd compare -> o_valid=0, flags 0 and o_ready=1 before the next edge; a new compare after release behaves normally.
- Parameter sweep, (WIDTH, CHUNK) = (16, 1), (32, 32), (64, 8): randomised operands against a behavioural reference model; latency equals the position of the first differing chunk from the MSB.
